// File: rtl/axi_lite_slave.sv
// axi_lite_slave: AXI4-Lite slave bridging bus writes/reads to a decoded register-access port.
// Optional BRESP/RRESP outputs are enabled by defining AXI_LITE_SLAVE_RESP_EN.
module axi_lite_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_valid
`ifdef AXI_LITE_SLAVE_RESP_EN
  ,
  output logic [1:0]            BRESP,
  output logic [1:0]            RRESP
`endif
);
  localparam logic [1:0] W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_WAIT = 2'd2, R_DATA = 2'd3;
  logic [1:0] w_state_q, w_state_d, r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q, wen_q, ren_q;
  always_comb begin
    w_state_d = w_state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (w_state_q)
      W_IDLE: if (AWVALID && WVALID) begin
        w_state_d = W_ACK;
        waddr_d = AWADDR;
        wdata_d = WDATA;
      end
      W_ACK: w_state_d = W_RESP;
      W_RESP: w_state_d = BREADY ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    case (r_state_q)
      R_IDLE: if (ARVALID) begin
        r_state_d = R_ADDR;
        raddr_d = ARADDR;
      end
      R_ADDR, R_WAIT: if (read_valid) begin
        r_state_d = R_DATA;
        rdata_d = read_data;
      end else begin
        r_state_d = R_WAIT;
      end
      default: r_state_d = RREADY ? R_IDLE : R_DATA;
    endcase
  end
  // Outputs are flopped from the next state so every port comes straight from a register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      rdata_q <= '0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      wen_q <= 1'b0;
      bvalid_q <= 1'b0;
      arready_q <= 1'b0;
      ren_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      awready_q <= w_state_d == W_ACK;
      wready_q <= w_state_d == W_ACK;
      wen_q <= w_state_d == W_ACK;
      bvalid_q <= w_state_d == W_RESP;
      arready_q <= r_state_d == R_ADDR;
      ren_q <= r_state_d == R_ADDR || r_state_d == R_WAIT;
      rvalid_q <= r_state_d == R_DATA;
    end
  end
  assign AWREADY = awready_q;
  assign WREADY = wready_q;
  assign BVALID = bvalid_q;
  assign ARREADY = arready_q;
  assign RVALID = rvalid_q;
  assign RDATA = rdata_q;
  assign write_en = wen_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign read_en = ren_q;
  assign read_addr = raddr_q;
`ifdef AXI_LITE_SLAVE_RESP_EN
  assign BRESP = 2'b00;
  assign RRESP = 2'b00;
`endif
endmodule

// File: tb/tb_axi_lite_slave.sv
// tb_axi_lite_slave: scoreboard bench for axi_lite_slave with a register-file peripheral model.
module tb_axi_lite_slave;
  logic ACLK, ARESET;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [4:0] AWADDR, ARADDR, write_addr, read_addr;
  logic [31:0] WDATA, RDATA, write_data, read_data;
  logic write_en, read_en, read_valid;
  int errors = 0, checks = 0;
  int rd_delay = 0, wait_cnt = 0;
  bit [31:0] periph [32];
  bit [31:0] mem [32];
  logic [36:0] wq [$];
  logic [31:0] rq [$];
  logic [4:0] raq [$];
  logic [36:0] mon_w;

  axi_lite_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Peripheral: stores strobed writes, answers reads after rd_delay cycles of read_en.
  always @(posedge ACLK) begin
    if (write_en) periph[write_addr] <= write_data;
    wait_cnt <= read_en ? wait_cnt + 1 : 0;
  end
  assign read_valid = read_en && (wait_cnt >= rd_delay);
  assign read_data = periph[read_addr];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (write_en) begin
        if (wq.size() == 0) chk("unexpected_write_en", 1, 0);
        else begin
          mon_w = wq.pop_front();
          chk("write_addr", write_addr, mon_w[36:32]);
          chk("write_data", write_data, mon_w[31:0]);
          chk("wready_with_wen", {AWREADY, WREADY}, 2'b11);
        end
      end
      if (ARREADY) begin
        if (raq.size() == 0) chk("unexpected_arready", 1, 0);
        else chk("read_addr", read_addr, raq.pop_front());
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) chk("unexpected_rvalid", 1, 0);
        else chk("rdata", RDATA, rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input int bdelay, input int pre);
    wq.push_back({a, d});
    mem[a] = d;
    AWADDR = a;
    WDATA = d;
    AWVALID = 1'b1;
    WVALID = (pre == 0);
    for (int i = 0; i < pre; i++) begin
      tick();
      chk("split_no_awready", {AWREADY, write_en}, 2'b00);
    end
    WVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID = 1'b0;
    chk("aw_w_ready", {AWREADY, WREADY}, 2'b11);
    tick();
    chk("bvalid_on", BVALID, 1);
    AWVALID = (bdelay > 0);
    WVALID = (bdelay > 0);
    AWADDR = a + 5'd1;
    for (int i = 0; i < bdelay; i++) begin
      tick();
      chk("bvalid_hold", BVALID, 1);
      chk("aw_blocked", AWREADY, 0);
    end
    AWVALID = 1'b0;
    WVALID = 1'b0;
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bvalid_off", BVALID, 0);
  endtask

  task automatic do_read(input logic [4:0] a, input int rdelay, input int rrdelay);
    int n;
    raq.push_back(a);
    rq.push_back(mem[a]);
    rd_delay = rdelay;
    ARADDR = a;
    ARVALID = 1'b1;
    RREADY = (rrdelay == 0);
    tick();
    ARVALID = 1'b0;
    chk("arready_pulse", {ARREADY, read_en}, 2'b11);
    n = 0;
    while (!RVALID && n < 20) begin
      chk("read_en_held", read_en, 1);
      tick();
      n++;
    end
    chk("read_latency", n, 1 + rdelay);
    ARVALID = (rrdelay > 0);
    ARADDR = a + 5'd3;
    for (int i = 0; i < rrdelay; i++) begin
      tick();
      chk("rvalid_hold", RVALID, 1);
      chk("rdata_stable", RDATA, mem[a]);
      chk("ar_blocked", {ARREADY, read_en}, 2'b00);
    end
    ARVALID = 1'b0;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("rvalid_off", RVALID, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [4:0] a, b;
    ARESET = 1'b1;
    {AWVALID, WVALID, BREADY, ARVALID, RREADY} = '0;
    AWADDR = '0;
    ARADDR = '0;
    WDATA = '0;
    repeat (3) tick();
    chk("rst_ctrl", {AWREADY, WREADY, BVALID, ARREADY, RVALID, write_en, read_en}, 0);
    chk("rst_data", {RDATA, write_data}, 0);
    chk("rst_addr", {write_addr, read_addr}, 0);
    ARESET = 1'b0;
    tick();
    chk("idle_ready", {AWREADY, WREADY, ARREADY}, 0);
    do_write(5'h05, 32'hDEADBEEF, 0, 0);
    do_read(5'h05, 0, 0);
    do_write(5'h09, $urandom, 5, 0);
    do_read(5'h09, 0, 5);
    do_write(5'h03, $urandom, 1, 4);
    do_read(5'h03, 3, 0);
    // reset during W_RESP
    wq.push_back({5'h0a, 32'h1234_5678});
    mem[5'h0a] = 32'h1234_5678;
    AWADDR = 5'h0a;
    WDATA = 32'h1234_5678;
    AWVALID = 1'b1;
    WVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID = 1'b0;
    tick();
    chk("midrst_bvalid_before", BVALID, 1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    chk("midrst_bvalid_after", {BVALID, AWREADY}, 0);
    // reset during R_WAIT
    raq.push_back(5'h0a);
    rd_delay = 10;
    ARADDR = 5'h0a;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    tick();
    tick();
    chk("midrst_ren_before", read_en, 1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    chk("midrst_read_after", {RVALID, read_en, ARREADY}, 0);
    do_write(5'h05, 32'hCAFEF00D, 0, 0);
    do_read(5'h0a, 0, 0);
    do_read(5'h05, 1, 1);
    // concurrent write and read to distinct addresses
    fork
      do_write(5'h11, $urandom, 2, 0);
      do_read(5'h03, 2, 1);
    join
    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom);
      b = 5'($urandom);
      if (a == b) b = a + 5'd1;
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        1: do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
        default: fork
          do_write(a, $urandom, $urandom_range(0, 3), 0);
          do_read(b, $urandom_range(0, 3), $urandom_range(0, 3));
        join
      endcase
    end
    repeat (3) tick();
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("raq_drained", raq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
